sp_ram_param: RTL and testbench
===============================

SP_RAM_PARAM -- requirements
Module: sp_ram_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8: word width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 5: address width in bits.
REQ-003 SHALL have parameter DEPTH, default 32: number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port req, input, 1: access request.
REQ-007 SHALL have port we, input, 1: 1 = write, 0 = read; sampled with req.
REQ-008 SHALL have port addr, input, ADDR_W: word address.
REQ-009 SHALL have port wdata, input, DATA_W: write data.
REQ-010 SHALL have port be, input, DATA_W/8: byte enables; bit i covers wdata[8i+7:8i].
REQ-011 SHALL have port ready, output, 1: block can accept a request this cycle.
REQ-012 SHALL have port rdata, output, DATA_W: registered read data.
REQ-013 SHALL have port rvalid, output, 1: rdata updated by an accepted read.
REQ-014 SHALL have port err, output, 1: pulse for an out-of-range access.

Function
REQ-015 SHALL accept a request on a rising edge where req && ready; requests while ready=0 are ignored and are not queued.
REQ-016 SHALL write an accepted write at that edge: only the bytes whose be bit is 1 are updated; be=0 is a legal no-op write.
REQ-017 SHALL capture mem[addr] into rdata at the accepting edge of a read and drive rvalid=1 for exactly the following cycle (1-cycle latency).
REQ-018 SHALL hold rdata at its last value when no read is accepted; writes SHALL never change rdata or rvalid.
REQ-019 SHALL support back-to-back accepted requests every cycle while in IDLE, with rvalid high on consecutive cycles for consecutive reads.
REQ-020 SHALL treat addr >= DEPTH as out-of-range: a write leaves memory unchanged; a read loads rdata=0 with rvalid=1; err=1 for the cycle after acceptance.
REQ-021 SHALL drive err=0 at all other times.
REQ-022 SHALL implement a state machine with states CLEAR and IDLE; ready=1 only in IDLE.
REQ-023 SHALL use a clear counter of width ADDR_W+1 wherever it counts to DEPTH, so that DEPTH = 2**ADDR_W cannot wrap early.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously force ready=0, rvalid=0, err=0, rdata=0 and the clear counter to 0.
REQ-025 SHALL not reset memory contents through rst_n; memory is cleared only by the CLEAR state (see Configuration).
REQ-026 SHALL abandon any clear in progress when reset is asserted mid-clear; the clear restarts from address 0 after release.
REQ-027 SHALL keep reads accepted on the last edge before reset from producing rvalid after reset.

Configuration
REQ-028 SHALL use macro SP_RAM_CLEAR_EN to compile in the post-reset memory clear.
REQ-029 SHALL, with SP_RAM_CLEAR_EN defined: reset state is CLEAR; each rising edge writes mem[cnt]=0 and increments cnt; the edge with cnt=DEPTH-1 enters IDLE. Ready therefore rises after DEPTH edges following reset release.
REQ-030 SHALL, without SP_RAM_CLEAR_EN: reset state is IDLE; ready=1 from the first rising edge after reset release; memory is uninitialised until written; the CLEAR state and its counter are absent.

Verification
REQ-031 SHALL cover, with CLEAR_EN and defaults: release rst_n -> ready=0 for 32 edges, then 1; reads of addr 0..31 return 0x00.
REQ-032 SHALL cover: write addr 5, wdata 0xA5, be=1, then read addr 5 -> rvalid=1 one cycle after acceptance, rdata=0xA5.
REQ-033 SHALL cover, with DATA_W=32: write 0x11223344 be=4'hF, then 0xAABBCCDD be=4'b0101 to the same address; read -> 0x11BB33DD.
REQ-034 SHALL cover, with DEPTH=20, ADDR_W=5: write addr 25, then read addr 25 -> err pulses 1 cycle after each access; read rdata=0, rvalid=1; no memory word changes.
REQ-035 SHALL cover: reads to addresses 1, 2, 3 on consecutive cycles -> rvalid high for 3 consecutive cycles with the matching data in order.
REQ-036 SHALL cover: assert rst_n=0 at clear count 10 -> outputs zero immediately; after release, the clear restarts and ready rises after a full DEPTH edges.

Source files
------------

// File: rtl/sp_ram_param.sv
// Single-port byte-enabled RAM with registered read data and out-of-range error pulse.
// Define SP_RAM_CLEAR_EN to zero the whole array after every reset before accepting requests.
module sp_ram_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              err
);
    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              accept;
    logic              in_range;
    logic              clear_we;
    logic [ADDR_W-1:0] clear_idx;

    // Extra MSB keeps the compare honest when DEPTH == 2**ADDR_W.
    assign in_range = {1'b0, addr} < DEPTH_C;
    assign accept   = req && ready;

`ifdef SP_RAM_CLEAR_EN
    localparam logic [ADDR_W:0] LAST_C = (ADDR_W+1)'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_C) begin
                state_d = IDLE;
            end
        end
    end

    assign ready     = (state_q == IDLE);
    assign clear_we  = (state_q == CLEAR);
    assign clear_idx = cnt_q[ADDR_W-1:0];
`else
    logic ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign ready     = ready_q;
    assign clear_we  = 1'b0;
    assign clear_idx = '0;
`endif

    // Array has no reset; contents survive rst_n unless the clear sweep runs.
    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem_q[clear_idx] <= '0;
        end else if (accept && we && in_range) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              err_q, err_d;

    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        if (accept) begin
            err_d = !in_range;
            if (!we) begin
                rvalid_d = 1'b1;
                rdata_d  = in_range ? mem_q[addr] : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign err    = err_q;
endmodule

// File: tb/tb_sp_ram_param.sv
// Bench for sp_ram_param: three instances (8b/32 words, 32b/32 words, 8b/20 words) share one stimulus.
// Builds with or without SP_RAM_CLEAR_EN; the model follows the same macro.
module tb_sp_ram_param;
`ifdef SP_RAM_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif
    localparam int WID [3] = '{8, 32, 8};
    localparam int DEP [3] = '{32, 32, 20};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;

    logic        r0, r1, r2, rv0, rv1, rv2, er0, er1, er2;
    logic [7:0]  rd0, rd2;
    logic [31:0] rd1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sp_ram_param #(.DATA_W(8), .ADDR_W(5), .DEPTH(32)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
        .wdata(wdata[7:0]), .be(be[0:0]),
        .ready(r0), .rdata(rd0), .rvalid(rv0), .err(er0));
    sp_ram_param #(.DATA_W(32), .ADDR_W(5), .DEPTH(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .be(be),
        .ready(r1), .rdata(rd1), .rvalid(rv1), .err(er1));
    sp_ram_param #(.DATA_W(8), .ADDR_W(5), .DEPTH(20)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
        .wdata(wdata[7:0]), .be(be[0:0]),
        .ready(r2), .rdata(rd2), .rvalid(rv2), .err(er2));

    logic        act_ready [3];
    logic        act_rvalid [3];
    logic        act_err [3];
    logic [31:0] act_rdata [3];
    assign act_ready[0] = r0;  assign act_ready[1] = r1;  assign act_ready[2] = r2;
    assign act_rvalid[0] = rv0; assign act_rvalid[1] = rv1; assign act_rvalid[2] = rv2;
    assign act_err[0] = er0;   assign act_err[1] = er1;   assign act_err[2] = er2;
    assign act_rdata[0] = {24'b0, rd0};
    assign act_rdata[1] = rd1;
    assign act_rdata[2] = {24'b0, rd2};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: word arrays with a known-bit mask, and a count of edges since reset release.
    logic [31:0] m_mem [3][32];
    logic [31:0] m_known [3][32];
    int          m_e = 0;
    logic        exp_ready [3];
    logic        exp_rvalid [3];
    logic        exp_err [3];
    logic [31:0] exp_rdata [3];
    logic [31:0] exp_rmask [3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            for (int a = 0; a < 32; a++) begin
                m_mem[i][a] = '0;
                m_known[i][a] = '0;
            end
            exp_ready[i] = 1'b0; exp_rvalid[i] = 1'b0; exp_err[i] = 1'b0;
            exp_rdata[i] = '0;   exp_rmask[i] = '1;
        end
    end

    always @(negedge clk) begin
        logic [31:0] wm, bm;
        bit rdy, inr;
        if (!rst_n) begin
            m_e = 0;
            for (int i = 0; i < 3; i++) begin
                exp_ready[i] = 1'b0; exp_rvalid[i] = 1'b0; exp_err[i] = 1'b0;
                exp_rdata[i] = '0;   exp_rmask[i] = '1;
            end
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("ready%0d", i), 32'(act_ready[i]), 32'(exp_ready[i]));
            check($sformatf("rvalid%0d", i), 32'(act_rvalid[i]), 32'(exp_rvalid[i]));
            check($sformatf("err%0d", i), 32'(act_err[i]), 32'(exp_err[i]));
            if (exp_rmask[i] != 0)
                check($sformatf("rdata%0d", i), act_rdata[i] & exp_rmask[i], exp_rdata[i] & exp_rmask[i]);
        end
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                wm  = (WID[i] == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
                rdy = CLR ? (m_e >= DEP[i]) : (m_e >= 1);
                if (CLR && m_e < DEP[i]) begin
                    m_mem[i][m_e] = '0;
                    m_known[i][m_e] = wm;
                end
                exp_rvalid[i] = 1'b0;
                exp_err[i] = 1'b0;
                if (req && rdy) begin
                    inr = int'(addr) < DEP[i];
                    exp_err[i] = !inr;
                    if (!we) begin
                        exp_rvalid[i] = 1'b1;
                        exp_rdata[i] = inr ? (m_mem[i][addr] & wm) : 32'h0;
                        exp_rmask[i] = inr ? (m_known[i][addr] & wm) : wm;
                    end else if (inr) begin
                        bm = '0;
                        for (int b = 0; b < WID[i] / 8; b++)
                            if (be[b]) bm[8*b +: 8] = 8'hFF;
                        m_mem[i][addr] = (m_mem[i][addr] & ~bm) | (wdata & bm);
                        m_known[i][addr] = m_known[i][addr] | bm;
                    end
                end
            end
            if (m_e < 1000) m_e++;
            for (int i = 0; i < 3; i++)
                exp_ready[i] = CLR ? (m_e >= DEP[i]) : (m_e >= 1);
        end
    end

    task automatic op(input logic w, input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        req = 1'b0; we = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic measure_ready();
        int n0, n2;
        n0 = 0; n2 = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (r2 && n2 == 0) n2 = k;
            if (r0 && n0 == 0) begin n0 = k; break; end
        end
        check("edges_to_ready0", 32'(n0), CLR ? 32'd32 : 32'd1);
        check("edges_to_ready2", 32'(n2), CLR ? 32'd20 : 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(r0), 32'd0);
        check("rst_rvalid", 32'(rv1), 32'd0);
        check("rst_rdata", rd1, 32'd0);
        rst_n = 1'b1;
        measure_ready();

        for (int a = 0; a < 32; a++) op(1'b0, 5'(a), 32'h0, 4'h0);
        if (CLR) check("clear_rd31", 32'(rd0), 32'h0);
        idle(1);

        op(1'b1, 5'd5, 32'h0000_00A5, 4'h1);
        check("wr_no_rvalid", 32'(rv0), 32'd0);
        op(1'b0, 5'd5, 32'h0, 4'h0);
        check("rd5_rvalid", 32'(rv0), 32'd1);
        check("rd5_data", 32'(rd0), 32'hA5);
        idle(1);
        check("rd5_rvalid_drop", 32'(rv0), 32'd0);
        check("rd5_hold", 32'(rd0), 32'hA5);

        op(1'b1, 5'd7, 32'h1122_3344, 4'hF);
        op(1'b1, 5'd7, 32'hAABB_CCDD, 4'b0101);
        op(1'b0, 5'd7, 32'h0, 4'h0);
        check("be_merge32", rd1, 32'h11BB_33DD);
        check("be_merge8", 32'(rd0), 32'hDD);
        idle(1);

        op(1'b1, 5'd25, 32'h0000_005A, 4'hF);
        check("oor_wr_err", 32'(er2), 32'd1);
        check("inr_wr_err", 32'(er0), 32'd0);
        op(1'b0, 5'd25, 32'h0, 4'h0);
        check("oor_rd_err", 32'(er2), 32'd1);
        check("oor_rd_rvalid", 32'(rv2), 32'd1);
        check("oor_rd_data", 32'(rd2), 32'h0);
        check("inr_rd25", 32'(rd0), 32'h5A);
        idle(1);
        check("oor_err_pulse", 32'(er2), 32'd0);

        op(1'b1, 5'd5, 32'h0000_00FF, 4'h0);
        op(1'b0, 5'd5, 32'h0, 4'h0);
        check("be0_noop", 32'(rd0), 32'hA5);

        op(1'b1, 5'd1, 32'h0000_0011, 4'hF);
        op(1'b1, 5'd2, 32'h0000_0022, 4'hF);
        op(1'b1, 5'd3, 32'h0000_0033, 4'hF);
        op(1'b0, 5'd1, 32'h0, 4'h0);
        check("b2b_1", {23'b0, rv0, rd0}, {23'b0, 1'b1, 8'h11});
        op(1'b0, 5'd2, 32'h0, 4'h0);
        check("b2b_2", {23'b0, rv0, rd0}, {23'b0, 1'b1, 8'h22});
        op(1'b0, 5'd3, 32'h0, 4'h0);
        check("b2b_3", {23'b0, rv0, rd0}, {23'b0, 1'b1, 8'h33});
        idle(1);
        check("b2b_end", 32'(rv0), 32'd0);

        // Read accepted on the last edge before reset.
        op(1'b0, 5'd7, 32'h0, 4'h0);
        check("pre_rst_rvalid", 32'(rv1), 32'd1);
        req = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_rvalid", 32'(rv1), 32'd0);
        check("async_rdata", rd1, 32'd0);
        check("async_ready", 32'(r1), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        check("no_stale_rvalid", 32'(rv1), 32'd0);

        // Reset at clear count 10, then a full clear must follow.
        rst_n = 1'b0;
        #1;
        check("midclr_ready", 32'(r0), 32'd0);
        check("midclr_err", 32'(er2), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        req = 1'b1; we = 1'b1; addr = 5'd3; wdata = 32'hFFFF_FFFF; be = 4'hF;
        measure_ready();
        req = 1'b0; we = 1'b0;
        op(1'b0, 5'd7, 32'h0, 4'h0);
        if (CLR) check("reclear_rd7", rd1, 32'h0);
        op(1'b0, 5'd3, 32'h0, 4'h0);
        if (CLR) check("ignored_wr3", rd1, 32'h0);
        for (int a = 0; a < 32; a++) op(1'b0, 5'(a), 32'h0, 4'h0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
